// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 16-bit ALU between two requesters.
// Stage 1 registers the winning operands into the ALU; stage 2 registers the result back.
module alu_arbiter #(
  parameter int N = 16,
  parameter int O = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_A,
  input  logic [N-1:0] req0_B,
  input  logic [O-1:0] req0_Op,
  input  logic         req0_Cin,
  input  logic         req0_invA,
  input  logic         req0_invB,
  input  logic         req0_sign,
  input  logic [N-1:0] req1_A,
  input  logic [N-1:0] req1_B,
  input  logic [O-1:0] req1_Op,
  input  logic         req1_Cin,
  input  logic         req1_invA,
  input  logic         req1_invB,
  input  logic         req1_sign,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [O-1:0] alu_Op,
  output logic         alu_Cin,
  output logic         alu_invA,
  output logic         alu_invB,
  output logic         alu_sign,
  input  logic [N-1:0] alu_Out,
  input  logic         alu_Ofl,
  input  logic         alu_Zero,
  input  logic         alu_Neg,
  output logic [1:0]   rsp_valid,
  output logic [N-1:0] rsp_Out,
  output logic         rsp_Ofl,
  output logic         rsp_Zero,
  output logic         rsp_Neg,
  output logic         idle
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [O-1:0] op;
    logic         cin;
    logic         inva;
    logic         invb;
    logic         sign;
  } opnd_t;

  opnd_t        req_opnd [2];
  opnd_t        s1_opnd_reg;
  logic         s1_valid_reg;
  logic         s1_id_reg;
  logic         s2_valid_reg;
  logic         s2_id_reg;
  logic [N-1:0] s2_out_reg;
  logic         s2_ofl_reg;
  logic         s2_zero_reg;
  logic         s2_neg_reg;
  logic         last_grant_reg;
  logic         xfer;
  logic         win_id;

  assign req_opnd[0] = {req0_A, req0_B, req0_Op, req0_Cin, req0_invA, req0_invB, req0_sign};
  assign req_opnd[1] = {req1_A, req1_B, req1_Op, req1_Cin, req1_invA, req1_invB, req1_sign};

  // Requester gi wins when it is the only one asking, or the other one won last time.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_arb
      assign req_ready[gi] = !stall && req_valid[gi] &&
                             (!req_valid[1-gi] || (last_grant_reg != 1'(gi)));
    end
  endgenerate

  assign xfer   = |(req_valid & req_ready);
  assign win_id = req_ready[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_id_reg      <= 1'b0;
      s1_opnd_reg    <= '0;
      s2_valid_reg   <= 1'b0;
      s2_id_reg      <= 1'b0;
      s2_out_reg     <= '0;
      s2_ofl_reg     <= 1'b0;
      s2_zero_reg    <= 1'b0;
      s2_neg_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        s1_opnd_reg    <= req_opnd[win_id];
        s1_id_reg      <= win_id;
        last_grant_reg <= win_id;
      end
      // Result stage keeps advancing regardless of stall.
      s2_valid_reg <= s1_valid_reg;
      s2_id_reg    <= s1_id_reg;
      if (s1_valid_reg) begin
        s2_out_reg  <= alu_Out;
        s2_ofl_reg  <= alu_Ofl;
        s2_zero_reg <= alu_Zero;
        s2_neg_reg  <= alu_Neg;
      end
    end
  end

  assign alu_A    = s1_opnd_reg.a;
  assign alu_B    = s1_opnd_reg.b;
  assign alu_Op   = s1_opnd_reg.op;
  assign alu_Cin  = s1_opnd_reg.cin;
  assign alu_invA = s1_opnd_reg.inva;
  assign alu_invB = s1_opnd_reg.invb;
  assign alu_sign = s1_opnd_reg.sign;

  assign rsp_valid = s2_valid_reg ? (s2_id_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_Out   = s2_out_reg;
  assign rsp_Ofl   = s2_ofl_reg;
  assign rsp_Zero  = s2_zero_reg;
  assign rsp_Neg   = s2_neg_reg;
  assign idle      = !s1_valid_reg && !s2_valid_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cycle table, flag/reset sequences, then random
// traffic against a queue-based model of grants and response ordering.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req0_A, req0_B, req1_A, req1_B;
  logic [3:0]  req0_Op, req1_Op;
  logic        req0_Cin, req0_invA, req0_invB, req0_sign;
  logic        req1_Cin, req1_invA, req1_invB, req1_sign;
  logic [15:0] alu_A, alu_B, alu_Out;
  logic [3:0]  alu_Op;
  logic        alu_Cin, alu_invA, alu_invB, alu_sign;
  logic        alu_Ofl, alu_Zero, alu_Neg;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_Out;
  logic        rsp_Ofl, rsp_Zero, rsp_Neg;
  logic        idle;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_Op(req0_Op), .req0_Cin(req0_Cin),
    .req0_invA(req0_invA), .req0_invB(req0_invB), .req0_sign(req0_sign),
    .req1_A(req1_A), .req1_B(req1_B), .req1_Op(req1_Op), .req1_Cin(req1_Cin),
    .req1_invA(req1_invA), .req1_invB(req1_invB), .req1_sign(req1_sign),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_Cin(alu_Cin),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
    .alu_Out(alu_Out), .alu_Ofl(alu_Ofl), .alu_Zero(alu_Zero), .alu_Neg(alu_Neg),
    .rsp_valid(rsp_valid), .rsp_Out(rsp_Out), .rsp_Ofl(rsp_Ofl),
    .rsp_Zero(rsp_Zero), .rsp_Neg(rsp_Neg), .idle(idle)
  );

  typedef struct packed {
    logic [15:0] out;
    logic        ofl;
    logic        zero;
    logic        neg;
  } res_t;

  // External ALU: op 0 add (carry or signed overflow), 1 and, 2 or, 3 xor, else pass A.
  function automatic res_t alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                 input logic cin, input logic ia, input logic ib, input logic sg);
    logic [15:0] x, y;
    logic [16:0] s;
    res_t r;
    x = ia ? ~a : a;
    y = ib ? ~b : b;
    s = {1'b0, x} + {1'b0, y} + {16'd0, cin};
    r.ofl = 1'b0;
    case (op)
      4'd0: begin
        r.out = s[15:0];
        r.ofl = sg ? ((x[15] == y[15]) && (s[15] != x[15])) : s[16];
      end
      4'd1:    r.out = x & y;
      4'd2:    r.out = x | y;
      4'd3:    r.out = x ^ y;
      default: r.out = x;
    endcase
    r.zero = (r.out == 16'd0);
    r.neg  = r.out[15];
    return r;
  endfunction

  res_t alu_r;
  always_comb begin
    alu_r    = alu_f(alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB, alu_sign);
    alu_Out  = alu_r.out;
    alu_Ofl  = alu_r.ofl;
    alu_Zero = alu_r.zero;
    alu_Neg  = alu_r.neg;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; req_valid = 2'b00;
    req0_A = 0; req0_B = 0; req0_Op = 0; req0_Cin = 0; req0_invA = 0; req0_invB = 0; req0_sign = 0;
    req1_A = 0; req1_B = 0; req1_Op = 0; req1_Cin = 0; req1_invA = 0; req1_invB = 0; req1_sign = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic        st;
    logic [15:0] a0, b0;
    logic [1:0]  rdy, rv;
    logic [15:0] out, aa;
    logic        idl;
  } row_t;

  function automatic row_t mk(input logic [1:0] v, input logic st, input logic [15:0] a0,
                              input logic [15:0] b0, input logic [1:0] rdy, input logic [1:0] rv,
                              input logic [15:0] out, input logic [15:0] aa, input logic idl);
    row_t r;
    r.v = v; r.st = st; r.a0 = a0; r.b0 = b0; r.rdy = rdy; r.rv = rv;
    r.out = out; r.aa = aa; r.idl = idl;
    return r;
  endfunction

  localparam int NR = 20;
  row_t tbl [NR];

  typedef struct {
    int   due;
    int   id;
    res_t r;
  } ent_t;

  initial begin
    ent_t q[$];
    ent_t e;
    res_t hold;
    logic [1:0] exp_rdy, exp_rv;
    logic model_last;
    logic exp_idle;
    int cyc;

    // Cycle table: inputs applied each cycle, outputs expected in that same cycle.
    tbl[0]  = mk(2'b01, 0, 16'h3,  16'h4,  2'b01, 2'b00, 16'h0000, 16'h0000, 1);
    tbl[1]  = mk(2'b00, 0, 16'h3,  16'h4,  2'b00, 2'b00, 16'h0000, 16'h0003, 0);
    tbl[2]  = mk(2'b00, 0, 16'h3,  16'h4,  2'b00, 2'b01, 16'h0007, 16'h0003, 0);
    tbl[3]  = mk(2'b00, 0, 16'h3,  16'h4,  2'b00, 2'b00, 16'h0007, 16'h0003, 1);
    tbl[4]  = mk(2'b00, 0, 16'h3,  16'h4,  2'b00, 2'b00, 16'h0007, 16'h0003, 1);
    tbl[5]  = mk(2'b00, 0, 16'h3,  16'h4,  2'b00, 2'b00, 16'h0007, 16'h0003, 1);
    tbl[6]  = mk(2'b11, 0, 16'h10, 16'h01, 2'b10, 2'b00, 16'h0007, 16'h0003, 1);
    tbl[7]  = mk(2'b11, 0, 16'h10, 16'h01, 2'b01, 2'b00, 16'h0007, 16'h0020, 0);
    tbl[8]  = mk(2'b11, 0, 16'h10, 16'h01, 2'b10, 2'b10, 16'h0022, 16'h0010, 0);
    tbl[9]  = mk(2'b11, 1, 16'h10, 16'h01, 2'b00, 2'b01, 16'h0011, 16'h0020, 0);
    tbl[10] = mk(2'b11, 1, 16'h10, 16'h01, 2'b00, 2'b10, 16'h0022, 16'h0020, 0);
    tbl[11] = mk(2'b11, 1, 16'h10, 16'h01, 2'b00, 2'b00, 16'h0022, 16'h0020, 1);
    tbl[12] = mk(2'b11, 0, 16'h10, 16'h01, 2'b01, 2'b00, 16'h0022, 16'h0020, 1);
    tbl[13] = mk(2'b11, 0, 16'h10, 16'h01, 2'b10, 2'b00, 16'h0022, 16'h0010, 0);
    tbl[14] = mk(2'b00, 0, 16'h10, 16'h01, 2'b00, 2'b01, 16'h0011, 16'h0020, 0);
    tbl[15] = mk(2'b00, 0, 16'h10, 16'h01, 2'b00, 2'b10, 16'h0022, 16'h0020, 0);
    tbl[16] = mk(2'b00, 0, 16'h10, 16'h01, 2'b00, 2'b00, 16'h0022, 16'h0020, 1);
    tbl[17] = mk(2'b10, 0, 16'h10, 16'h01, 2'b10, 2'b00, 16'h0022, 16'h0020, 1);
    tbl[18] = mk(2'b00, 0, 16'h10, 16'h01, 2'b00, 2'b00, 16'h0022, 16'h0020, 0);
    tbl[19] = mk(2'b00, 0, 16'h10, 16'h01, 2'b00, 2'b10, 16'h0022, 16'h0020, 0);

    do_reset();
    req1_A = 16'h20; req1_B = 16'h02;
    @(negedge clk);
    chk("reset alu_A", 32'(alu_A), 0);
    chk("reset rsp_Out", 32'(rsp_Out), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset idle", 32'(idle), 1);
    chk("reset ready", 32'(req_ready), 0);

    for (int i = 0; i < NR; i++) begin
      @(posedge clk); #1;
      req_valid = tbl[i].v; stall = tbl[i].st; req0_A = tbl[i].a0; req0_B = tbl[i].b0;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rv));
      chk($sformatf("row%0d rsp_Out", i), 32'(rsp_Out), 32'(tbl[i].out));
      chk($sformatf("row%0d alu_A", i), 32'(alu_A), 32'(tbl[i].aa));
      chk($sformatf("row%0d idle", i), 32'(idle), 32'(tbl[i].idl));
    end

    // Flags routed to requester 1: signed 0x8000 + 0x8000.
    @(posedge clk); #1;
    req_valid = 2'b10; req1_A = 16'h8000; req1_B = 16'h8000; req1_sign = 1'b1;
    @(negedge clk);
    chk("flags ready", 32'(req_ready), 32'(2'b10));
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("flags alu_B", 32'(alu_B), 32'h8000);
    @(negedge clk);
    chk("flags rsp_valid", 32'(rsp_valid), 32'(2'b10));
    chk("flags rsp_Out", 32'(rsp_Out), 0);
    chk("flags rsp_Zero", 32'(rsp_Zero), 1);
    chk("flags rsp_Ofl", 32'(rsp_Ofl), 1);
    chk("flags rsp_Neg", 32'(rsp_Neg), 0);

    // Reset between transfer and capture discards the op.
    @(posedge clk); #1;
    req_valid = 2'b01; req0_A = 16'h5; req0_B = 16'h6;
    @(negedge clk);
    chk("midrst ready", 32'(req_ready), 32'(2'b01));
    @(posedge clk); #1 req_valid = 2'b00;
    #1 rst = 1'b1;
    #1;
    chk("midrst alu_A", 32'(alu_A), 0);
    chk("midrst rsp_Out", 32'(rsp_Out), 0);
    chk("midrst rsp_Ofl", 32'(rsp_Ofl), 0);
    chk("midrst idle", 32'(idle), 1);
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("midrst no rsp %0d", i), 32'(rsp_valid), 0);
      chk($sformatf("midrst idle %0d", i), 32'(idle), 1);
    end
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("midrst first grant", 32'(req_ready), 32'(2'b01));
    @(posedge clk); #1 req_valid = 2'b00;

    // Random traffic checked against a grant rule plus an in-order response queue.
    do_reset();
    model_last = 1'b1;
    hold = '0;
    cyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      stall     = ($urandom_range(0, 7) == 0);
      req0_A = 16'($urandom); req0_B = 16'($urandom); req0_Op = 4'($urandom_range(0, 5));
      req0_Cin = 1'($urandom); req0_invA = 1'($urandom); req0_invB = 1'($urandom); req0_sign = 1'($urandom);
      req1_A = 16'($urandom); req1_B = 16'($urandom); req1_Op = 4'($urandom_range(0, 5));
      req1_Cin = 1'($urandom); req1_invA = 1'($urandom); req1_invB = 1'($urandom); req1_sign = 1'($urandom);
      @(negedge clk);

      if (stall || req_valid == 2'b00) exp_rdy = 2'b00;
      else if (req_valid == 2'b11)     exp_rdy = model_last ? 2'b01 : 2'b10;
      else                             exp_rdy = req_valid;
      chk($sformatf("rnd%0d ready", n), 32'(req_ready), 32'(exp_rdy));

      exp_idle = (q.size() == 0);
      chk($sformatf("rnd%0d idle", n), 32'(idle), 32'(exp_idle));

      exp_rv = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        exp_rv = (e.id == 1) ? 2'b10 : 2'b01;
        hold = e.r;
      end
      chk($sformatf("rnd%0d rsp_valid", n), 32'(rsp_valid), 32'(exp_rv));
      chk($sformatf("rnd%0d rsp_Out", n), 32'(rsp_Out), 32'(hold.out));
      chk($sformatf("rnd%0d rsp_flags", n), 32'({rsp_Ofl, rsp_Zero, rsp_Neg}),
          32'({hold.ofl, hold.zero, hold.neg}));

      if (exp_rdy != 2'b00) begin
        e.due = cyc + 2;
        e.id  = exp_rdy[1] ? 1 : 0;
        if (exp_rdy[1])
          e.r = alu_f(req1_A, req1_B, req1_Op, req1_Cin, req1_invA, req1_invB, req1_sign);
        else
          e.r = alu_f(req0_A, req0_B, req0_Op, req0_Cin, req0_invA, req0_invB, req0_sign);
        q.push_back(e);
        model_last = exp_rdy[1];
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and 2-stage issue pipeline that shares one 16-bit ALU between two clients (e.g. the execute-stage datapath and a secondary address/branch unit). It accepts operand bundles via valid/ready, picks a winner round-robin, registers the winning operands into the ALU, and registers the ALU result plus flags back to the winning requester one cycle later. The ALU itself is external; this block drives its inputs from its operand register and samples its combinational outputs.

## Interface
- N, 16, datapath width
- O, 4, ALU opcode width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  when high, no new request is granted; in-flight ops still complete
- req_valid[1:0]  in  2  per-requester request valid
- req_ready[1:0]  out  2  per-requester grant; transfer when valid&&ready
- req0_A, req0_B / req1_A, req1_B  in  N each  operands
- req0_Op / req1_Op  in  O  ALU opcode
- req0_Cin, req0_invA, req0_invB, req0_sign (same for req1)  in  1 each  ALU controls
- alu_A, alu_B  out  N  to ALU, from operand register
- alu_Op  out  O; alu_Cin, alu_invA, alu_invB, alu_sign  out  1 each
- alu_Out  in  N; alu_Ofl, alu_Zero, alu_Neg  in  1 each  ALU results (combinational)
- rsp_valid[1:0]  out  2  one-cycle pulse, bit i = result for requester i
- rsp_Out  out  N; rsp_Ofl, rsp_Zero, rsp_Neg  out  1 each  registered result, shared by both requesters
- idle  out  1  high when neither pipeline stage holds a valid op

## Operation
- Arbitration (combinational): if stall, req_ready=2'b00. Else if only one valid, that one is ready. If both valid, grant the requester not granted last (last_grant flop). At most one req_ready bit high; req_ready[i] never high while req_valid[i] is low.
- last_grant updates only on an actual transfer; reset value 1 (requester 0 wins first contention).
- Stage 1 (operand register): on transfer, load winner's A, B, Op, Cin, invA, invB, sign, id; s1_valid=1. No transfer: s1_valid=0; operand fields hold their previous value (alu_* outputs do not glitch to zero).
- Stage 2 (result register): each edge, s2_valid<=s1_valid, s2_id<=s1_id; when s1_valid, capture alu_Out, alu_Ofl, alu_Zero, alu_Neg. rsp_valid = s2_valid ? (1<<s2_id) : 0. rsp_Out/flags hold last result when s2_valid=0.
- No backpressure on responses: requester must accept rsp_valid when it pulses.
- stall affects only grants; stage 1->2 advance continues.
- idle = !s1_valid && !s2_valid.
- Reset (any time, including mid-operation): s1_valid, s2_valid, rsp_valid, all operand/result registers cleared to 0; last_grant=1; in-flight ops are discarded with no response. Outputs after reset: req_ready follows arbitration rules, alu_* = 0, rsp_* = 0, idle=1.

## Timing
- Transfer at edge T -> alu_* valid after T -> result captured at edge T+1 -> rsp_valid high for the cycle after T+1 (2-edge latency).
- Throughput: one accepted op per cycle, continuously; back-to-back ops from the same or alternating requesters allowed.
- Both valid every cycle: grants strictly alternate 0,1,0,1... starting from requester not last granted.
- Results return in accept order; rsp id always matches the granted requester of that op.

## Test plan
- Single op: after reset, req_valid=2'b01, req0_A=0x0003, req0_B=0x0004, ALU model ADD -> req_ready=01 same cycle; alu_A=0x0003 next cycle; rsp_valid=01, rsp_Out=0x0007 two edges after transfer; idle back to 1.
- Contention: both valid continuously for 6 cycles -> grants 0,1,0,1,0,1; rsp_valid sequence 01,10,01,10,01,10 offset by 2 cycles, each rsp_Out matching that requester's operands.
- Stall: assert stall the cycle after a transfer, with both valid -> req_ready=00 while stalled; pending op still returns rsp_valid 2 edges after its transfer; grants resume with correct round-robin order on stall release.
- Flags routing: req1 computes 0x8000+0x8000 on model with Ofl -> rsp_valid=10, rsp_Out=0x0000, rsp_Zero=1, rsp_Ofl=1, rsp_Neg=0.
- Reset mid-flight: transfer at edge T, assert rst between T and T+1 -> no rsp_valid ever issued for it; all outputs 0, idle=1; first post-reset contention grants requester 0.
- Sparse/idle: req_valid=00 for 3 cycles after an op -> rsp_Out and alu_* hold last values, rsp_valid=00, idle=1.
